mode_counter: RTL and testbench

Programmable up/down counter with parallel load: the device under test driven by the counter verification environment's driver, with its `Q`, `RCO` and `LOAD` outputs compared cycle-by-cycle against the scoreboard model. It counts up by 1, down by 1, or down by 3, or loads `D`, as selected by `MODO`. It flags wrap/borrow on `RCO` and parallel loads on `LOAD`.

---
 rtl/mode_counter.sv | 87 ++++++++
 tb/tb_mode_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// Programmable up/down counter with parallel load: +1, -1, -3 or load D per MODO.
// RCO flags wrap/borrow, LOAD flags a parallel load; both are registered one-cycle pulses.
module mode_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             LOAD
);

  typedef enum logic [1:0] {
    S_RST,
    S_HOLD,
    S_COUNT,
    S_LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             load_q, load_d;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_RST;
      q_q     <= '0;
      rco_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rco_q   <= rco_d;
      load_q  <= load_d;
    end
  end

  // The extra top bit of sum is the carry/borrow; it becomes RCO and is dropped from Q.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rco_d   = 1'b0;
    load_d  = 1'b0;
    sum     = '0;
    if (state_q == S_RST) begin
      state_d = S_HOLD;
    end else if (!ENABLE) begin
      state_d = S_HOLD;
    end else begin
      unique case (MODO)
        2'b00: begin
          sum     = {1'b0, q_q} + (WIDTH+1)'(1);
          q_d     = sum[WIDTH-1:0];
          rco_d   = sum[WIDTH];
          state_d = S_COUNT;
        end
        2'b01: begin
          sum     = {1'b0, q_q} - (WIDTH+1)'(1);
          q_d     = sum[WIDTH-1:0];
          rco_d   = sum[WIDTH];
          state_d = S_COUNT;
        end
        2'b10: begin
          sum     = {1'b0, q_q} - (WIDTH+1)'(3);
          q_d     = sum[WIDTH-1:0];
          rco_d   = sum[WIDTH];
          state_d = S_COUNT;
        end
        default: begin
          q_d     = D;
          load_d  = 1'b1;
          state_d = S_LOAD;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign RCO  = rco_q;
  assign LOAD = load_q;

endmodule

// File: tb/tb_mode_counter.sv
// Directed and model-checked bench for mode_counter at WIDTH=4.
module tb_mode_counter;

  logic       clk;
  logic       RESET;
  logic       ENABLE;
  logic [1:0] MODO;
  logic [3:0] D;
  logic [3:0] Q;
  logic       RCO;
  logic       LOAD;

  int checks;
  int failures;

  mode_counter #(.WIDTH(4)) dut (
    .clk    (clk),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .MODO   (MODO),
    .D      (D),
    .Q      (Q),
    .RCO    (RCO),
    .LOAD   (LOAD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int eq, input int er, input int el);
    checkOutput({tag, ".Q"}, 32'(Q), 32'(eq));
    checkOutput({tag, ".RCO"}, 32'(RCO), 32'(er));
    checkOutput({tag, ".LOAD"}, 32'(LOAD), 32'(el));
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the following edge.
  task automatic applyStimulus(input logic en, input logic [1:0] m, input logic [3:0] d);
    ENABLE = en;
    MODO   = m;
    D      = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  mq, mr, ml;
    bit  in_rst;
    logic       ren;
    logic [1:0] rm;
    logic [3:0] rd;
    checks   = 0;
    failures = 0;
    RESET    = 1'b0;
    ENABLE   = 1'b1;
    MODO     = 2'b00;
    D        = 4'd0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b00, 4'd0);
      checkAll("reset_hold", 0, 0, 0);
    end
    RESET = 1'b1;
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("first_edge", 0, 0, 0);
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("up_1", 1, 0, 0);
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("up_2", 2, 0, 0);
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("up_3", 3, 0, 0);
    applyStimulus(1'b1, 2'b00, 4'd0);
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("up_5", 5, 0, 0);

    #2 RESET = 1'b0;
    #1 checkAll("async_reset", 0, 0, 0);
    RESET = 1'b1;
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("first_edge_2", 0, 0, 0);

    applyStimulus(1'b1, 2'b11, 4'd14);
    checkAll("load_14", 14, 0, 1);
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("wrap_15", 15, 0, 0);
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("wrap_0", 0, 1, 0);
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("wrap_1", 1, 0, 0);

    applyStimulus(1'b1, 2'b11, 4'd1);
    checkAll("load_1", 1, 0, 1);
    applyStimulus(1'b1, 2'b01, 4'd0);
    checkAll("dn1_0", 0, 0, 0);
    applyStimulus(1'b1, 2'b01, 4'd0);
    checkAll("dn1_15", 15, 1, 0);

    applyStimulus(1'b1, 2'b11, 4'd4);
    checkAll("load_4", 4, 0, 1);
    applyStimulus(1'b1, 2'b10, 4'd0);
    checkAll("dn3_1", 1, 0, 0);
    applyStimulus(1'b1, 2'b10, 4'd0);
    checkAll("dn3_14", 14, 1, 0);

    applyStimulus(1'b1, 2'b11, 4'd7);
    checkAll("load_7", 7, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'(i), 4'd9);
      checkAll("hold", 7, 0, 0);
    end

    applyStimulus(1'b1, 2'b11, 4'd15);
    checkAll("b2b_15", 15, 0, 1);
    applyStimulus(1'b1, 2'b11, 4'd0);
    checkAll("b2b_0", 0, 0, 1);
    applyStimulus(1'b1, 2'b11, 4'd3);
    checkAll("b2b_3", 3, 0, 1);
    applyStimulus(1'b1, 2'b10, 4'd0);
    checkAll("sw_dn3", 0, 0, 0);
    applyStimulus(1'b1, 2'b01, 4'd0);
    checkAll("sw_dn1", 15, 1, 0);
    applyStimulus(1'b1, 2'b00, 4'd0);
    checkAll("sw_up", 0, 1, 0);

    // Random run against an integer reference model; one reset pulse lands mid-cycle at step 50.
    mq = 0;
    mr = 0;
    ml = 0;
    in_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ren = 1'($urandom_range(0, 1));
      rm  = 2'($urandom_range(0, 3));
      rd  = 4'($urandom_range(0, 15));
      ENABLE = ren;
      MODO   = rm;
      D      = rd;
      RESET  = (i != 50);
      if (i == 50) begin
        #2 checkOutput("rand_async_q", 32'(Q), 32'd0);
      end
      @(posedge clk);
      #1;
      if (i == 50) begin
        mq = 0; mr = 0; ml = 0; in_rst = 1'b1;
      end else if (in_rst) begin
        mr = 0; ml = 0; in_rst = 1'b0;
      end else if (!ren) begin
        mr = 0; ml = 0;
      end else begin
        ml = 0;
        case (rm)
          2'd0: begin mr = (mq == 15) ? 1 : 0; mq = (mq + 1) % 16;  end
          2'd1: begin mr = (mq == 0) ? 1 : 0;  mq = (mq + 15) % 16; end
          2'd2: begin mr = (mq < 3) ? 1 : 0;   mq = (mq + 13) % 16; end
          default: begin mr = 0; ml = 1; mq = int'(rd); end
        endcase
      end
      checkAll("rand", mq, mr, ml);
      checkOutput("rand_excl", 32'(RCO & LOAD), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
